// File: rtl/ramport_responder.sv
// Toggle-handshake RAM port responder: fixed-latency word access with byte enables.
// Optional macro RAMPORT_CLKREF_EN gates acceptance on a synchronized clkref rising edge.
module ramport_responder #(
   parameter int AW      = 16,
   parameter int LATENCY = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          port_req,
   input  logic [AW-1:0] port_a,
   input  logic [1:0]    port_ds,
   input  logic          port_we,
   input  logic [15:0]   port_d,
   input  logic          clkref,
   output logic          port_ack,
   output logic [15:0]   port_q,
   output logic          busy,
   output logic          proto_err
);

   localparam int         DEPTH      = 2 ** (AW - 1);
   localparam logic [3:0] CNT_LOAD   = 4'(LATENCY - 1);
   localparam logic       FAST_DONE  = (LATENCY == 1);

`ifdef RAMPORT_CLKREF_EN
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_ARM} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
`endif

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          ack_q, ack_d;
   logic [15:0]   q_q, q_d;
   logic          busy_q, busy_d;
   logic          perr_q, perr_d;
   logic          req_prev_q, req_prev_d;
   logic [AW-2:0] a_q, a_d;
   logic [1:0]    ds_q, ds_d;
   logic          we_q, we_d;
   logic [15:0]   dat_q, dat_d;

   logic [15:0]   mem [DEPTH];
   logic          pending;
   logic          accept;
   logic          mem_wr;

   assign pending = port_req ^ ack_q;

`ifdef RAMPORT_CLKREF_EN
   logic cr_s1_q, cr_s2_q, cr_s3_q;
   logic cr_rise;
   logic unused_bits;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cr_s1_q <= 1'b0;
         cr_s2_q <= 1'b0;
         cr_s3_q <= 1'b0;
      end else begin
         cr_s1_q <= clkref;
         cr_s2_q <= cr_s1_q;
         cr_s3_q <= cr_s2_q;
      end
   end

   assign cr_rise     = cr_s2_q & ~cr_s3_q;
   assign accept      = (state_q == S_ARM) && pending && cr_rise;
   assign unused_bits = port_a[0];
`else
   logic unused_bits;
   assign accept      = (state_q == S_IDLE) && pending;
   assign unused_bits = ^{clkref, port_a[0]};
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         ack_q      <= 1'b0;
         q_q        <= '0;
         busy_q     <= 1'b0;
         perr_q     <= 1'b0;
         req_prev_q <= 1'b0;
         a_q        <= '0;
         ds_q       <= '0;
         we_q       <= 1'b0;
         dat_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ack_q      <= ack_d;
         q_q        <= q_d;
         busy_q     <= busy_d;
         perr_q     <= perr_d;
         req_prev_q <= req_prev_d;
         a_q        <= a_d;
         ds_q       <= ds_d;
         we_q       <= we_d;
         dat_q      <= dat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (accept) begin
         state_d = FAST_DONE ? S_DONE : S_WAIT;
         cnt_d   = CNT_LOAD;
      end else begin
         case (state_q)
`ifdef RAMPORT_CLKREF_EN
            S_IDLE: if (pending) state_d = S_ARM;
            S_ARM:  if (!pending) state_d = S_IDLE;
`endif
            S_WAIT: begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q <= 4'd1) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = state_q;
         endcase
      end
   end

   // Requests are only latched at acceptance, so changes while busy never alter the access.
   always_comb begin
      ack_d      = ack_q;
      q_d        = q_q;
      busy_d     = busy_q;
      a_d        = a_q;
      ds_d       = ds_q;
      we_d       = we_q;
      dat_d      = dat_q;
      mem_wr     = 1'b0;
      req_prev_d = port_req;
      perr_d     = perr_q | (busy_q & (port_req ^ req_prev_q));
      if (accept) begin
         a_d    = port_a[AW-1:1];
         ds_d   = port_ds;
         we_d   = port_we;
         dat_d  = port_d;
         busy_d = 1'b1;
      end
      if (state_q == S_DONE) begin
         ack_d  = ~ack_q;
         busy_d = 1'b0;
         mem_wr = we_q;
         if (!we_q) q_d = mem[a_q];
      end
   end

   always_ff @(posedge clk) begin
      if (mem_wr) begin
         if (ds_q[0]) mem[a_q][7:0]  <= dat_q[7:0];
         if (ds_q[1]) mem[a_q][15:8] <= dat_q[15:8];
      end
   end

   assign port_ack  = ack_q;
   assign port_q    = q_q;
   assign busy      = busy_q;
   assign proto_err = perr_q;

endmodule

// File: tb/tb_ramport_responder.sv
// Randomized self-checking bench for ramport_responder against a word-array model.
module tb_ramport_responder;

   localparam int LAT = 4;

   logic clk = 1'b0;
   logic rst;
   logic clkref = 1'b0;
   always #5 clk = ~clk;

   logic        a_req, a_we, a_ack, a_busy, a_perr;
   logic [15:0] a_addr, a_d, a_q;
   logic [1:0]  a_ds;

   logic        b_req, b_we, b_ack, b_busy, b_perr;
   logic [7:0]  b_addr;
   logic [15:0] b_d, b_q;
   logic [1:0]  b_ds;

   ramport_responder #(.AW(16), .LATENCY(LAT)) u_dut (
      .clk(clk), .reset(rst), .port_req(a_req), .port_a(a_addr), .port_ds(a_ds),
      .port_we(a_we), .port_d(a_d), .clkref(clkref), .port_ack(a_ack), .port_q(a_q),
      .busy(a_busy), .proto_err(a_perr));

   ramport_responder #(.AW(8), .LATENCY(1)) u_dut1 (
      .clk(clk), .reset(rst), .port_req(b_req), .port_a(b_addr), .port_ds(b_ds),
      .port_we(b_we), .port_d(b_d), .clkref(clkref), .port_ack(b_ack), .port_q(b_q),
      .busy(b_busy), .proto_err(b_perr));

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int cr_cnt = 0;
   int cr_rise_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // clkref: period 24 clk, changes on the falling edge of clk
   always @(negedge clk) begin
      if (cr_cnt == 11) begin
         cr_cnt = 0;
         clkref = ~clkref;
         if (clkref) cr_rise_cyc = cyc;
      end else begin
         cr_cnt = cr_cnt + 1;
      end
   end

   logic [15:0] model [int];
   logic [15:0] a_exp_q;

   function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] d,
                                         input logic [1:0] ds);
      return {ds[1] ? d[15:8] : o[15:8], ds[0] ? d[7:0] : o[7:0]};
   endfunction

   task automatic acc_a(input logic we, input logic [15:0] addr, input logic [1:0] ds,
                        input logic [15:0] d, output int lat);
      @(negedge clk);
      a_we = we; a_addr = addr; a_ds = ds; a_d = d;
      a_req = ~a_req;
      lat = 0;
      for (int i = 1; i <= 64; i++) begin
         @(posedge clk); #1;
         if (a_ack === a_req) begin
            lat = i;
            break;
         end
      end
      if (we) model[int'(addr[15:1])] = merge(model[int'(addr[15:1])], d, ds);
      else    a_exp_q = model[int'(addr[15:1])];
   endtask

   task automatic test_reset;
      rst = 1'b1;
      a_req = 0; a_we = 0; a_addr = 0; a_ds = 0; a_d = 0;
      b_req = 0; b_we = 0; b_addr = 0; b_ds = 0; b_d = 0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (a_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got=%b want=0", a_ack); end
      n_cmp++; if (a_q !== 16'h0) begin n_err++; $display("FAIL reset_q got=%h want=0000", a_q); end
      n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", a_busy); end
      n_cmp++; if (a_perr !== 1'b0) begin n_err++; $display("FAIL reset_perr got=%b want=0", a_perr); end
      n_cmp++; if (b_ack !== 1'b0) begin n_err++; $display("FAIL reset_b_ack got=%b want=0", b_ack); end
      @(negedge clk);
      rst = 1'b0;
      a_exp_q = 16'h0;
   endtask

   task automatic test_directed;
      int lat;
      logic [1:0] dss [5] = '{2'b11, 2'b00, 2'b01, 2'b00, 2'b00};
      logic       wes [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [15:0] ads [5] = '{16'h0010, 16'h0011, 16'h0010, 16'h0010, 16'h0010};
      logic [15:0] dts [5] = '{16'hA55A, 16'h0000, 16'h1234, 16'h0000, 16'hFFFF};
      logic [15:0] qs  [5] = '{16'h0000, 16'hA55A, 16'hA55A, 16'hA534, 16'hA534};
      for (int k = 0; k < 5; k++) begin
         acc_a(wes[k], ads[k], dss[k], dts[k], lat);
`ifndef RAMPORT_CLKREF_EN
         n_cmp++; if (lat != LAT + 1) begin n_err++; $display("FAIL dir_latency[%0d] got=%0d want=%0d", k, lat, LAT + 1); end
`else
         n_cmp++; if (lat == 0) begin n_err++; $display("FAIL dir_timeout[%0d] got=0 want>0", k); end
`endif
         n_cmp++; if (a_q !== qs[k]) begin n_err++; $display("FAIL dir_q[%0d] got=%h want=%h", k, a_q, qs[k]); end
      end
      acc_a(1'b0, 16'h0011, 2'b10, 16'h0, lat);
      n_cmp++; if (a_q !== 16'hA534) begin n_err++; $display("FAIL dir_ds00_unchanged got=%h want=a534", a_q); end
   endtask

   task automatic test_random;
      int lat;
      logic [14:0] pool [8];
      logic we;
      logic [14:0] w;
      logic [15:0] addr, d;
      logic [1:0] ds;
      pool[0] = 15'h7FFF;
      pool[1] = 15'h0000;
      for (int i = 2; i < 8; i++) pool[i] = 15'($urandom_range(0, 32767));
      for (int i = 0; i < 8; i++) begin
         acc_a(1'b1, {pool[i], 1'b0}, 2'b11, 16'($urandom), lat);
      end
      for (int k = 0; k < 30; k++) begin
         we = 1'($urandom_range(0, 1));
         w = pool[$urandom_range(0, 7)];
         addr = {w, 1'($urandom_range(0, 1))};
         ds = 2'($urandom_range(0, 3));
         d = 16'($urandom);
         acc_a(we, addr, ds, d, lat);
`ifndef RAMPORT_CLKREF_EN
         n_cmp++; if (lat != LAT + 1) begin n_err++; $display("FAIL rnd_latency[%0d] got=%0d want=%0d", k, lat, LAT + 1); end
`endif
         n_cmp++; if (a_q !== a_exp_q) begin n_err++; $display("FAIL rnd_q[%0d] we=%b a=%h got=%h want=%h", k, we, addr, a_q, a_exp_q); end
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] bmod [4];
      logic [15:0] exp_b;
      int n;
      exp_b = 16'h0;
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         b_we = (k < 4);
         b_addr = {5'd0, 2'(k % 4), 1'b0};
         b_ds = 2'b11;
         b_d = 16'($urandom);
         if (k < 4) bmod[k] = b_d;
         else exp_b = bmod[k - 4];
         b_req = ~b_req;
         n = 0;
         for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            n = i;
            if (b_ack === b_req) break;
            n_cmp++; if (b_busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy_high[%0d] got=%b want=1", k, b_busy); end
         end
         n_cmp++; if (n != 2) begin n_err++; $display("FAIL b2b_period[%0d] got=%0d want=2", k, n); end
         n_cmp++; if (b_busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_low[%0d] got=%b want=0", k, b_busy); end
         n_cmp++; if (b_q !== exp_b) begin n_err++; $display("FAIL b2b_q[%0d] got=%h want=%h", k, b_q, exp_b); end
      end
   endtask

   task automatic test_proto_err;
      int lat;
      logic ack0;
      logic [15:0] exp_v;
      exp_v = model[8];
      ack0 = a_ack;
      @(negedge clk);
      a_we = 1'b0; a_addr = 16'h0010; a_ds = 2'b11;
      a_req = ~a_req;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (a_busy === 1'b1) break;
      end
      n_cmp++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL perr_busy got=%b want=1", a_busy); end
      @(negedge clk); a_req = ~a_req;
      @(negedge clk); a_req = ~a_req;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (a_ack !== ack0) break;
      end
      n_cmp++; if (a_ack !== ~ack0) begin n_err++; $display("FAIL perr_ack got=%b want=%b", a_ack, ~ack0); end
      n_cmp++; if (a_q !== exp_v) begin n_err++; $display("FAIL perr_q got=%h want=%h", a_q, exp_v); end
      n_cmp++; if (a_perr !== 1'b1) begin n_err++; $display("FAIL perr_set got=%b want=1", a_perr); end
      repeat (40) @(posedge clk);
      #1;
      n_cmp++; if (a_ack !== ~ack0) begin n_err++; $display("FAIL perr_no_second got=%b want=%b", a_ack, ~ack0); end
      n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL perr_idle_busy got=%b want=0", a_busy); end
      a_exp_q = exp_v;
      acc_a(1'b1, 16'h0020, 2'b11, 16'h5AA5, lat);
      n_cmp++; if (a_perr !== 1'b1) begin n_err++; $display("FAIL perr_sticky got=%b want=1", a_perr); end
   endtask

   task automatic test_reset_abort;
      logic [15:0] old_v;
      int lat;
      @(negedge clk);
      rst = 1'b1; a_req = 1'b0;
      @(negedge clk);
      n_cmp++; if (a_perr !== 1'b0) begin n_err++; $display("FAIL abort_perr_clear got=%b want=0", a_perr); end
      rst = 1'b0;
      old_v = model[16];
      @(negedge clk);
      a_we = 1'b1; a_addr = 16'h0020; a_ds = 2'b11; a_d = ~old_v;
      a_req = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      n_cmp++; if (a_ack !== 1'b0) begin n_err++; $display("FAIL abort_ack got=%b want=0", a_ack); end
      n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b want=0", a_busy); end
      a_we = 1'b0; a_addr = 16'h0021;
      @(negedge clk);
      rst = 1'b0;
      lat = 0;
      for (int i = 1; i <= 64; i++) begin
         @(posedge clk); #1;
         if (a_ack === 1'b1) begin lat = i; break; end
      end
`ifndef RAMPORT_CLKREF_EN
      n_cmp++; if (lat != LAT + 1) begin n_err++; $display("FAIL abort_reaccept_lat got=%0d want=%0d", lat, LAT + 1); end
`else
      n_cmp++; if (lat == 0) begin n_err++; $display("FAIL abort_reaccept_timeout got=0 want>0"); end
`endif
      n_cmp++; if (a_q !== old_v) begin n_err++; $display("FAIL abort_word_kept got=%h want=%h", a_q, old_v); end
      a_exp_q = old_v;
   endtask

`ifdef RAMPORT_CLKREF_EN
   task automatic test_clkref;
      int done_cyc;
      logic ack0;
      for (int i = 0; i < 30 && clkref !== 1'b1; i++) @(negedge clk);
      for (int i = 0; i < 30 && clkref !== 1'b0; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      ack0 = a_ack;
      a_we = 1'b0; a_addr = 16'h0010; a_ds = 2'b11;
      a_req = ~a_req;
      done_cyc = -1;
      for (int i = 0; i < 64; i++) begin
         @(posedge clk); #1;
         if (a_ack !== ack0) begin done_cyc = cyc; break; end
      end
      n_cmp++; if (done_cyc - cr_rise_cyc != 3 + LAT) begin n_err++; $display("FAIL clkref_latency got=%0d want=%0d", done_cyc - cr_rise_cyc, 3 + LAT); end
      n_cmp++; if (a_q !== model[8]) begin n_err++; $display("FAIL clkref_q got=%h want=%h", a_q, model[8]); end
   endtask
`endif

   initial begin
      test_reset;
      test_directed;
      test_random;
`ifndef RAMPORT_CLKREF_EN
      test_back_to_back;
`endif
      test_proto_err;
      test_reset_abort;
`ifdef RAMPORT_CLKREF_EN
      test_clkref;
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
